instruction_fetch: RTL

//  Fetch stage fed by program_counter. Each cycle it reads the instruction at i_pc from on-chip instruction

---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/instruction_memory.sv | 33 +++
 rtl/instruction_fetch.sv | 91 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, types and small helpers for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned NB     = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    localparam logic [NB-1:0] HALT_OP = 32'hFFFF_FFFF;
    localparam logic [NB-1:0] NOP_OP  = 32'h0000_0000;

    typedef logic [NB-1:0]     word_t;
    typedef logic [ADDR_W-1:0] waddr_t;

    // What the IF/ID register does on the coming edge.
    typedef enum logic [1:0] {
        FetchLoad,
        FetchHold,
        FetchFlush,
        FetchRun
    } fetch_op_e;

    // Loader beats everything; once halted, IF/ID is frozen even against a flush.
    function automatic fetch_op_e decode_op(
        input logic load_en,
        input logic halted,
        input logic flush,
        input logic stall
    );
        fetch_op_e op;
        if (load_en) begin
            op = FetchLoad;
        end else if (halted) begin
            op = FetchHold;
        end else if (flush) begin
            op = FetchFlush;
        end else if (stall) begin
            op = FetchHold;
        end else begin
            op = FetchRun;
        end
        return op;
    endfunction

    // Byte PC to word address; upper bits drop so fetches wrap modulo DEPTH.
    function automatic waddr_t word_addr(input word_t pc);
        return pc[ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction RAM: one write port, one registered read port with enable, no reset.
// A 1-bit predecode array marks HALT_OP words so fetch can see a halt before the read lands.
module instruction_memory
    import fetch_pkg::*;
(
    input  logic   clk_i,
    input  logic   we_i,
    input  waddr_t waddr_i,
    input  word_t  wdata_i,
    input  logic   re_i,
    input  waddr_t raddr_i,
    output word_t  rdata_o,
    output logic   peek_halt_o
);

    word_t              mem_q [DEPTH];
    logic [DEPTH-1:0]   halt_bits_q;
    word_t              rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i]       <= wdata_i;
            halt_bits_q[waddr_i] <= (wdata_i == HALT_OP);
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o     = rdata_q;
    assign peek_halt_o = halt_bits_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC+4 adder, next-PC mux, IF/ID register and sticky halt flag.
// The memory's read register doubles as the IF/ID instruction field.
module instruction_fetch
    import fetch_pkg::*;
(
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB-1:0]     i_pc,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_branch_taken,
    input  logic [NB-1:0]     i_branch_target,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [NB-1:0]     i_load_data,
    output logic [NB-1:0]     o_next_pc,
    output logic              o_pc_write,
    output logic [NB-1:0]     o_instruction,
    output logic [NB-1:0]     o_pc_plus4,
    output logic              o_valid,
    output logic              o_halt
);

    word_t     pc_plus4;
    word_t     mem_rdata;
    logic      fetched_halt;
    logic      mem_re;
    fetch_op_e op;

    logic  valid_d, valid_q;
    logic  halt_d, halt_q;
    word_t pc4_d, pc4_q;

    assign pc_plus4 = i_pc + NB'(4);
    assign op       = decode_op(i_load_en, halt_q, i_flush, i_stall);
    assign mem_re   = (op == FetchRun);

    instruction_memory u_imem (
        .clk_i       (i_clock),
        .we_i        (i_load_en),
        .waddr_i     (i_load_addr),
        .wdata_i     (i_load_data),
        .re_i        (mem_re),
        .raddr_i     (word_addr(i_pc)),
        .rdata_o     (mem_rdata),
        .peek_halt_o (fetched_halt)
    );

    always_comb begin
        o_next_pc  = i_branch_taken ? i_branch_target : pc_plus4;
        o_pc_write = ~i_stall & ~halt_q & ~i_load_en & ~fetched_halt;
    end

    always_comb begin
        valid_d = valid_q;
        halt_d  = halt_q;
        pc4_d   = pc4_q;
        unique case (op)
            FetchFlush: begin
                valid_d = 1'b0;
                pc4_d   = pc_plus4;
            end
            FetchRun: begin
                valid_d = 1'b1;
                pc4_d   = pc_plus4;
                halt_d  = halt_q | fetched_halt;
            end
            FetchLoad, FetchHold: begin
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            halt_q  <= halt_d;
            pc4_q   <= pc4_d;
        end
    end

    // Bubble masking makes reset and flush show NOP_OP without touching the RAM.
    assign o_instruction = valid_q ? mem_rdata : NOP_OP;
    assign o_pc_plus4    = pc4_q;
    assign o_valid       = valid_q;
    assign o_halt        = halt_q;

endmodule
